// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and owner encodings for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    OWN_IR = 2'd1,
    OWN_DR = 2'd2,
    OWN_DW = 2'd3
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_priority.sv
// rtl/mem_arb_priority.sv - combinational winner select: dw > dr > ir, with instruction-fetch starvation override
module mem_arb_priority
  import mem_arb_pkg::*;
(
  input  logic       i_ir_req,
  input  logic       i_dr_req,
  input  logic       i_dw_req,
  input  logic       i_ir_starved,
  output logic [1:0] o_winner
);

  always_comb begin
    o_winner = NONE;
    if (i_ir_req && i_ir_starved) o_winner = OWN_IR;
    else if (i_dw_req)            o_winner = OWN_DW;
    else if (i_dr_req)            o_winner = OWN_DR;
    else if (i_ir_req)            o_winner = OWN_IR;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one burst memory port between I-refill, D-refill and D-write-back
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LEN    = 4,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ir_req,
  input  logic [ADDR_WIDTH-1:0] ir_addr,
  output logic                  ir_grant,
  output logic                  ir_rvalid,
  input  logic                  dr_req,
  input  logic [ADDR_WIDTH-1:0] dr_addr,
  output logic                  dr_grant,
  output logic                  dr_rvalid,
  input  logic                  dw_req,
  input  logic [ADDR_WIDTH-1:0] dw_addr,
  input  logic [DATA_WIDTH-1:0] dw_wdata,
  output logic                  dw_grant,
  output logic                  dw_wnext,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_wready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  busy,
  output logic                  protocol_err
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  arb_owner_t            r_owner;
  arb_owner_t            w_winner;
  logic [1:0]            w_winner_raw;
  logic [BW-1:0]         r_beat_cnt;
  logic [SW-1:0]         r_streak_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  r_mem_we;
  logic                  r_protocol_err;
  logic                  w_starved;
  logic                  w_arb;
  logic                  w_rd_beat;
  logic                  w_wr_beat;
  logic                  w_last_beat;
  logic                  w_err;

  assign w_starved = ir_req && (r_streak_cnt == SW'(MAX_D_STREAK));

  mem_arb_priority u_prio (
    .i_ir_req    (ir_req),
    .i_dr_req    (dr_req),
    .i_dw_req    (dw_req),
    .i_ir_starved(w_starved),
    .o_winner    (w_winner_raw)
  );

  assign w_winner    = arb_owner_t'(w_winner_raw);
  assign w_arb       = (r_state == IDLE) && (w_winner != NONE);
  assign w_rd_beat   = (r_state == RDATA) && mem_rvalid;
  assign w_wr_beat   = (r_state == WDATA) && mem_wready;
  assign w_last_beat = (r_beat_cnt == BW'(BURST_LEN - 1));
  // Beats or grants in the wrong state are dropped and flagged; a stray wready during a read is flagged too
  assign w_err = (mem_rvalid && (r_state != RDATA)) ||
                 (mem_wready && (r_state != WDATA)) ||
                 (mem_gnt    && (r_state != CMD));

  always_comb begin
    case (w_winner)
      OWN_DW:  w_sel_addr = dw_addr;
      OWN_DR:  w_sel_addr = dr_addr;
      default: w_sel_addr = ir_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_arb) w_state_nxt = CMD;
      CMD:     if (mem_gnt) w_state_nxt = r_mem_we ? WDATA : RDATA;
      RDATA:   if (w_rd_beat && w_last_beat) w_state_nxt = IDLE;
      WDATA:   if (w_wr_beat && w_last_beat) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ir_grant  = w_arb && (w_winner == OWN_IR);
    dr_grant  = w_arb && (w_winner == OWN_DR);
    dw_grant  = w_arb && (w_winner == OWN_DW);
    ir_rvalid = w_rd_beat && (r_owner == OWN_IR);
    dr_rvalid = w_rd_beat && (r_owner == OWN_DR);
    dw_wnext  = w_wr_beat;
    mem_req   = (r_state == CMD);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner        <= NONE;
      r_beat_cnt     <= '0;
      r_streak_cnt   <= '0;
      r_mem_addr     <= '0;
      r_mem_we       <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_err) r_protocol_err <= 1'b1;
      if (w_arb) begin
        r_owner    <= w_winner;
        r_mem_addr <= w_sel_addr;
        r_mem_we   <= (w_winner == OWN_DW);
        // Streak only counts D-side wins that made a waiting I-fetch wait longer
        if ((w_winner == OWN_IR) || !ir_req) r_streak_cnt <= '0;
        else if (r_streak_cnt != SW'(MAX_D_STREAK)) r_streak_cnt <= r_streak_cnt + SW'(1);
      end
      if ((r_state == CMD) && mem_gnt) r_beat_cnt <= '0;
      if (w_rd_beat || w_wr_beat) begin
        r_beat_cnt <= r_beat_cnt + BW'(1);
        if (w_last_beat) r_owner <= NONE;
      end
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_we       = r_mem_we;
  assign protocol_err = r_protocol_err;
  assign rdata        = mem_rdata;
  assign mem_wdata    = dw_wdata;

endmodule
